// File: rtl/led_blink_pkg.sv
// led_blink_pkg: controller states, default widths and the burst-field extraction helper
// shared by the LED blink arbiter files.
package led_blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int CNT_W_DEF   = 25;
    localparam int BURST_W_DEF = 4;
    localparam int BURST_BUS_W = 64;
    localparam int BURST_MAX_W = 8;

    function automatic logic [BURST_MAX_W-1:0] burst_slice(
        input logic [BURST_BUS_W-1:0] bus,
        input int                     i,
        input int                     w
    );
        logic [BURST_BUS_W-1:0] mask;
        mask = (BURST_BUS_W'(1) << w) - BURST_BUS_W'(1);
        return BURST_MAX_W'((bus >> (i * w)) & mask);
    endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// led_rr_arbiter: combinational one-hot winner pick plus the last-winner pointer.
// With LED_BLINK_FIXED_PRIO_EN defined it collapses to a lowest-index priority encoder.
module led_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

`ifdef LED_BLINK_FIXED_PRIO_EN

    logic unused_pins;
    assign unused_pins = ^{clk, rst, en_i};

    // Descending scan: the last hit is the lowest requesting index.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

`else

    logic [IW-1:0] last_q, last_d;
    logic          found;

    // Search starts just above the previous winner, so it is served last next time.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_i[(int'(last_q) + k) % N]) begin
                found                           = 1'b1;
                gnt_o[(int'(last_q) + k) % N]   = 1'b1;
                idx_o                           = IW'((int'(last_q) + k) % N);
            end
        end
    end

    assign last_d = en_i ? idx_o : last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: grants one shared blink timebase to one requester at a time for a burst of LED toggles.
// Define LED_BLINK_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module led_blink_arbiter
    import led_blink_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(24_999_999),
    parameter int               BURST_W = BURST_W_DEF
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BURST_W-1:0] burst_len,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       led_out
);

    localparam int IW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BURST_W-1:0]   rem_q, rem_d, win_len;
    logic [IW-1:0]        owner_q, owner_d, win_idx;
    logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d, win_gnt;
    logic                 busy_q, busy_d, led_q, led_d, arb_en;

    led_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .req_i (req),
        .en_i  (arb_en),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

    assign win_len = BURST_W'(burst_slice(BURST_BUS_W'(burst_len), int'(win_idx), BURST_W));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        owner_d = owner_q;
        grant_d = grant_q;
        done_d  = '0;
        led_d   = led_q;
        arb_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    arb_en  = 1'b1;
                    owner_d = win_idx;
                    grant_d = win_gnt;
                    cnt_d   = '0;
                    led_d   = 1'b0;
                    rem_d   = win_len;
                    state_d = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    led_d   = 1'b0;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    led_d   = ~led_q;
                    rem_d   = rem_q - BURST_W'(rem_q != '0);
                    state_d = (rem_q == BURST_W'(1)) ? DONE : RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = grant_q;
                grant_d = '0;
                led_d   = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                led_d   = 1'b0;
            end
        endcase
        // The DONE term keeps busy high through the done-pulse cycle.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign led_out = led_q;

endmodule
